// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the programmable counter.
//   mode_t    : 2-bit operation code carried on imode
//   MODE_HOLD : 00, keep the current value
//   MODE_UP   : 01, count towards imax
//   MODE_DOWN : 10, count towards 0
//   MODE_LOAD : 11, take iload, clamped to imax
// ---------------------------------------------------------------------------
package counter_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_UP   = 2'b01,
      MODE_DOWN = 2'b10,
      MODE_LOAD = 2'b11
   } mode_t;

endpackage : counter_pkg

// File: rtl/counter_next.sv
// ---------------------------------------------------------------------------
// counter_next
// Purely combinational next-state logic for counter_prog.
//   ivalue  : current registered count
//   imode   : operation (hold/up/down/load)
//   isat    : 1 saturate at the limits, 0 wrap
//   imax    : inclusive upper limit of the counting range
//   iload   : value taken in load mode (clamped to imax)
//   ienable : 0 forces hold
//   onext   : value to register on the next edge
//   oevent  : wrap or saturation-block event (becomes ocarry)
// ---------------------------------------------------------------------------
module counter_next
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] ivalue,
   input  mode_t            imode,
   input  logic             isat,
   input  logic [WIDTH-1:0] imax,
   input  logic [WIDTH-1:0] iload,
   input  logic             ienable,
   output logic [WIDTH-1:0] onext,
   output logic             oevent
);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs; no latch can form.
      onext  = ivalue;
      oevent = 1'b0;
      if (ienable) begin
         unique case (imode)
            MODE_HOLD: ;
            MODE_UP: begin
               if (ivalue < imax) begin
                  onext = ivalue + 1'b1;
               end else begin
                  // At or beyond the limit (imax may have been lowered).
                  oevent = 1'b1;
                  onext  = isat ? imax : '0;
               end
            end
            MODE_DOWN: begin
               if (ivalue > imax) begin
                  // imax was lowered under us: snap back into range, no event.
                  onext = imax;
               end else if (ivalue == '0) begin
                  oevent = 1'b1;
                  onext  = isat ? '0 : imax;
               end else begin
                  onext = ivalue - 1'b1;
               end
            end
            MODE_LOAD: begin
               onext = (iload > imax) ? imax : iload;
            end
            default: ;
         endcase
      end
   end

endmodule : counter_next

// File: rtl/counter_prog.sv
// ---------------------------------------------------------------------------
// counter_prog
// Parametrised up/down/load counter with programmable modulus and
// wrap/saturate limit behaviour.
//   iclk     : clock, rising edge
//   iresetn  : asynchronous active-low reset
//   ienable  : count enable (0 holds in every mode)
//   imode    : 00 hold, 01 up, 10 down, 11 load
//   isat     : 1 saturate, 0 wrap
//   imax     : inclusive limit, range is 0..imax
//   iload    : load value for imode=11
//   iclear   : synchronous clear of osticky
//   ovalue   : registered count
//   otc      : terminal count, combinational from ovalue/imode/imax
//   ocarry   : registered one-cycle event pulse
//   osticky  : registered sticky event flag
// ---------------------------------------------------------------------------
module counter_prog
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned RESET_VALUE = 0
) (
   input  logic             iclk,
   input  logic             iresetn,
   input  logic             ienable,
   input  logic [1:0]       imode,
   input  logic             isat,
   input  logic [WIDTH-1:0] imax,
   input  logic [WIDTH-1:0] iload,
   input  logic             iclear,
   output logic [WIDTH-1:0] ovalue,
   output logic             otc,
   output logic             ocarry,
   output logic             osticky
);

   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

   mode_t            mode;
   logic [WIDTH-1:0] value_next;
   logic             event_next;
   logic             sticky_next;

   assign mode = mode_t'(imode);

   counter_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .ivalue  (ovalue),
      .imode   (mode),
      .isat    (isat),
      .imax    (imax),
      .iload   (iload),
      .ienable (ienable),
      .onext   (value_next),
      .oevent  (event_next)
   );

   // A new event beats a simultaneous clear, so a clear can never hide it.
   assign sticky_next = event_next | (osticky & ~iclear);

   always_ff @(posedge iclk or negedge iresetn) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      if (!iresetn) begin
         ovalue  <= RST_VAL;
         ocarry  <= 1'b0;
         osticky <= 1'b0;
      end else begin
         ovalue  <= value_next;
         ocarry  <= event_next;
         osticky <= sticky_next;
      end
   end

   assign otc = ((mode == MODE_UP)   && (ovalue >= imax)) ||
                ((mode == MODE_DOWN) && (ovalue == '0));

endmodule : counter_prog

// File: tb/tb_counter_prog.sv
// ---------------------------------------------------------------------------
// tb_counter_prog
// Self-checking bench for counter_prog (WIDTH=8, RESET_VALUE=0): directed
// reset/free-count sequence, a table of directed vectors, then randomized
// stimulus against a behavioural model.
// ---------------------------------------------------------------------------
module tb_counter_prog;
   import counter_pkg::*;

   logic       iclk;
   logic       iresetn;
   logic       ienable;
   logic [1:0] imode;
   logic       isat;
   logic [7:0] imax;
   logic [7:0] iload;
   logic       iclear;
   logic [7:0] ovalue;
   logic       otc;
   logic       ocarry;
   logic       osticky;

   int n_vec  = 0;
   int n_miss = 0;

   // behavioural model state
   int unsigned m_val;
   bit          m_carry;
   bit          m_sticky;

   typedef struct {
      bit          en;
      logic [1:0]  md;
      bit          sat;
      int unsigned mx;
      int unsigned ld;
      bit          clr;
      int unsigned e_val;
      bit          e_carry;
      bit          e_sticky;
      bit          e_tc;
   } vec_t;

   vec_t vecs[$];

   counter_prog #(
      .WIDTH       (8),
      .RESET_VALUE (0)
   ) dut (
      .iclk    (iclk),
      .iresetn (iresetn),
      .ienable (ienable),
      .imode   (imode),
      .isat    (isat),
      .imax    (imax),
      .iload   (iload),
      .iclear  (iclear),
      .ovalue  (ovalue),
      .otc     (otc),
      .ocarry  (ocarry),
      .osticky (osticky)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Counter rules in plain integer arithmetic.
   function automatic void model_next(input int unsigned v, input int md, input bit sat,
                                      input int unsigned mx, input int unsigned ld, input bit en,
                                      output int unsigned nv, output bit ev);
      nv = v;
      ev = 1'b0;
      if (en) begin
         case (md)
            1: if (v < mx) nv = v + 1; else begin ev = 1'b1; nv = sat ? mx : 0; end
            2: if (v > mx) nv = mx;
               else if (v == 0) begin ev = 1'b1; nv = sat ? 0 : mx; end
               else nv = v - 1;
            3: nv = (ld < mx) ? ld : mx;
            default: ;
         endcase
      end
   endfunction

   function automatic bit model_tc(input int unsigned v, input int md, input int unsigned mx);
      return (md == 1 && v >= mx) || (md == 2 && v == 0);
   endfunction

   // One clock edge; model advances using the inputs present at the edge.
   task automatic tick();
      int unsigned nv;
      bit          nc;
      bit          clr;
      model_next(m_val, int'(imode), isat, imax, iload, ienable, nv, nc);
      clr = iclear;
      @(posedge iclk);
      #1;
      m_sticky = nc | (m_sticky & !clr);
      m_val    = nv;
      m_carry  = nc;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".value"},  ovalue,  m_val);
      check({tag, ".carry"},  ocarry,  m_carry);
      check({tag, ".sticky"}, osticky, m_sticky);
      check({tag, ".tc"},     otc,     model_tc(m_val, int'(imode), imax));
   endtask

   function automatic void add(input bit en, input logic [1:0] md, input bit sat,
                               input int unsigned mx, input int unsigned ld, input bit clr,
                               input int unsigned ev, input bit ec, input bit es, input bit et);
      vec_t v;
      v.en = en; v.md = md; v.sat = sat; v.mx = mx; v.ld = ld; v.clr = clr;
      v.e_val = ev; v.e_carry = ec; v.e_sticky = es; v.e_tc = et;
      vecs.push_back(v);
   endfunction

   initial begin
      // modulus wrap 8,9,0,1
      add(1, MODE_LOAD, 0,   9,   8, 0,   8, 0, 0, 0);
      add(1, MODE_UP,   0,   9,   0, 0,   9, 0, 0, 1);
      add(1, MODE_UP,   0,   9,   0, 0,   0, 1, 1, 0);
      add(1, MODE_UP,   0,   9,   0, 0,   1, 0, 1, 0);
      // saturate down 3,2,1,0,0,0
      add(1, MODE_LOAD, 0,   9,   3, 0,   3, 0, 1, 0);
      add(1, MODE_DOWN, 1,   9,   0, 0,   2, 0, 1, 0);
      add(1, MODE_DOWN, 1,   9,   0, 0,   1, 0, 1, 0);
      add(1, MODE_DOWN, 1,   9,   0, 0,   0, 0, 1, 1);
      add(1, MODE_DOWN, 1,   9,   0, 0,   0, 1, 1, 1);
      add(1, MODE_DOWN, 1,   9,   0, 0,   0, 1, 1, 1);
      // load clamp, then imax drop in down mode
      add(1, MODE_LOAD, 0,  20,  50, 0,  20, 0, 1, 0);
      add(1, MODE_DOWN, 0,   5,   0, 0,   5, 0, 1, 0);
      // enable low holds
      add(1, MODE_LOAD, 0,  20,   6, 0,   6, 0, 1, 0);
      add(1, MODE_UP,   0,  20,   0, 0,   7, 0, 1, 0);
      add(0, MODE_UP,   0,  20,   0, 0,   7, 0, 1, 0);
      add(0, MODE_UP,   0,  20,   0, 0,   7, 0, 1, 0);
      add(0, MODE_UP,   0,  20,   0, 0,   7, 0, 1, 0);
      add(1, MODE_UP,   0,  20,   0, 0,   8, 0, 1, 0);
      // sticky clear race
      add(0, MODE_UP,   0,  20,   0, 1,   8, 0, 0, 0);
      add(1, MODE_LOAD, 0,   9,   8, 0,   8, 0, 0, 0);
      add(1, MODE_UP,   0,   9,   0, 0,   9, 0, 0, 1);
      add(1, MODE_UP,   0,   9,   0, 1,   0, 1, 1, 0);
      add(1, MODE_UP,   0,   9,   0, 1,   1, 0, 0, 0);
      // imax = 0
      add(1, MODE_LOAD, 0,   0,   0, 0,   0, 0, 0, 0);
      add(1, MODE_UP,   0,   0,   0, 0,   0, 1, 1, 1);
      add(1, MODE_DOWN, 0,   0,   0, 0,   0, 1, 1, 1);
      add(1, MODE_HOLD, 0,   0,   0, 0,   0, 0, 1, 0);
      // full-range saturate and natural wrap
      add(1, MODE_LOAD, 0, 255, 255, 0, 255, 0, 1, 0);
      add(1, MODE_UP,   1, 255,   0, 0, 255, 1, 1, 1);
      add(1, MODE_UP,   0, 255,   0, 0,   0, 1, 1, 0);

      // ---- free count with mid-count async reset ----
      iresetn = 1'b0;
      ienable = 1'b1;
      imode   = MODE_UP;
      isat    = 1'b0;
      imax    = 8'd255;
      iload   = 8'd0;
      iclear  = 1'b0;
      #2 iresetn = 1'b1;                       // t=2
      @(posedge iclk); #1;                     // t=6
      check("free.pre1", ovalue, 1);
      @(posedge iclk); #1;                     // t=16
      check("free.pre2", ovalue, 2);
      #1 iresetn = 1'b0;                       // t=17
      #1;                                      // t=18
      check("rst.value",  ovalue,  0);
      check("rst.carry",  ocarry,  0);
      check("rst.sticky", osticky, 0);
      #10 iresetn = 1'b1;                      // t=28
      check("rst.held", ovalue, 0);
      for (int i = 1; i <= 256; i++) begin
         @(posedge iclk); #1;
         check($sformatf("free.value[%0d]", i),  ovalue,  i % 256);
         check($sformatf("free.carry[%0d]", i),  ocarry,  (i == 256) ? 1 : 0);
         check($sformatf("free.sticky[%0d]", i), osticky, (i == 256) ? 1 : 0);
      end
      @(posedge iclk); #1;
      check("free.after.value",  ovalue,  1);
      check("free.after.carry",  ocarry,  0);
      check("free.after.sticky", osticky, 1);

      // ---- table-driven directed vectors ----
      iresetn = 1'b0;
      #2;
      check("rst2.value",  ovalue,  0);
      check("rst2.sticky", osticky, 0);
      iresetn = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         ienable = vecs[i].en;
         imode   = vecs[i].md;
         isat    = vecs[i].sat;
         imax    = 8'(vecs[i].mx);
         iload   = 8'(vecs[i].ld);
         iclear  = vecs[i].clr;
         @(posedge iclk); #1;
         check($sformatf("vec[%0d].value", i),  ovalue,  vecs[i].e_val);
         check($sformatf("vec[%0d].carry", i),  ocarry,  vecs[i].e_carry);
         check($sformatf("vec[%0d].sticky", i), osticky, vecs[i].e_sticky);
         check($sformatf("vec[%0d].tc", i),     otc,     vecs[i].e_tc);
      end

      // ---- randomized stimulus against the model ----
      iresetn = 1'b0;
      #1 iresetn = 1'b1;
      m_val = 0; m_carry = 0; m_sticky = 0;
      for (int i = 0; i < 3000; i++) begin
         ienable = ($urandom_range(0, 7) != 0);
         imode   = 2'($urandom_range(0, 3));
         isat    = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       imax = 8'($urandom_range(0, 3));
            1:       imax = 8'd255;
            default: imax = 8'($urandom_range(0, 40));
         endcase
         iload   = 8'($urandom_range(0, 255));
         iclear  = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 99) == 0) begin
            iresetn = 1'b0;
            #1;
            check($sformatf("rnd[%0d].rst.value", i),  ovalue,  0);
            check($sformatf("rnd[%0d].rst.carry", i),  ocarry,  0);
            check($sformatf("rnd[%0d].rst.sticky", i), osticky, 0);
            iresetn = 1'b1;
            m_val = 0; m_carry = 0; m_sticky = 0;
         end
         tick();
         check_model($sformatf("rnd[%0d]", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_counter_prog
